// File: rtl/main_decoder_stage.sv
// main_decoder_stage: registered main decoder between Decode and Execute.
// Decodes the 7-bit opcode into a control bundle, holds it in a single-entry
// pipeline register with a valid/ready handshake, supports flush, flags
// undecodable opcodes and keeps a saturating count of accepted illegal ones.
module main_decoder_stage #(
    parameter bit EN_JUMP   = 1'b1,
    parameter bit EN_UPPER  = 1'b1,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           Op,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 RegWrite,
    output logic [2:0]           ImmSrc,
    output logic                 ALUSrc,
    output logic                 MemWrite,
    output logic [1:0]           ResultSrc,
    output logic                 Branch,
    output logic                 Jump,
    output logic [1:0]           ALUOp,
    output logic                 illegal,
    output logic [ILL_CNT_W-1:0] ill_cnt
);

    typedef struct packed {
        logic       reg_write;
        logic [2:0] imm_src;
        logic       alu_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [ILL_CNT_W-1:0] ILL_CNT_MAX = '1;

    ctrl_t                ctrl_reg;
    ctrl_t                dec_ctrl;
    logic                 dec_illegal;
    logic                 valid_reg;
    logic                 illegal_reg;
    logic [ILL_CNT_W-1:0] ill_cnt_reg;
    logic                 acc;

    // The stage can take a new opcode whenever its register is empty or is
    // being drained this cycle; flush only blocks the accept itself.
    assign in_ready = !valid_reg || out_ready;
    assign acc      = in_valid && in_ready && !flush;

    // Opcode decode; disabled J/U classes fall through to illegal.
    always_comb begin
        dec_ctrl    = '0;
        dec_illegal = 1'b0;
        case (Op)
            OP_LOAD:   dec_ctrl = '{1'b1, 3'b000, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00};
            OP_STORE:  dec_ctrl = '{1'b0, 3'b001, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};
            OP_RTYPE:  dec_ctrl = '{1'b1, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10};
            OP_IALU:   dec_ctrl = '{1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
            OP_BRANCH: dec_ctrl = '{1'b0, 3'b010, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01};
            OP_JAL: begin
                if (EN_JUMP) dec_ctrl = '{1'b1, 3'b011, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 2'b00};
                else         dec_illegal = 1'b1;
            end
            OP_JALR: begin
                if (EN_JUMP) dec_ctrl = '{1'b1, 3'b000, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 2'b00};
                else         dec_illegal = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                if (EN_UPPER) dec_ctrl = '{1'b1, 3'b100, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00};
                else          dec_illegal = 1'b1;
            end
            default:   dec_illegal = 1'b1;
        endcase
    end

    // Pipeline register: flush beats accept beats drain; otherwise stall.
    // Controls are cleared whenever the entry leaves so downstream never
    // sees stale write enables while out_valid is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg   <= 1'b0;
            ctrl_reg    <= '0;
            illegal_reg <= 1'b0;
            ill_cnt_reg <= '0;
        end else if (flush) begin
            valid_reg   <= 1'b0;
            ctrl_reg    <= '0;
            illegal_reg <= 1'b0;
        end else if (acc) begin
            valid_reg   <= 1'b1;
            ctrl_reg    <= dec_ctrl;
            illegal_reg <= dec_illegal;
            if (dec_illegal && (ill_cnt_reg != ILL_CNT_MAX))
                ill_cnt_reg <= ill_cnt_reg + ILL_CNT_W'(1);
        end else if (valid_reg && out_ready) begin
            valid_reg   <= 1'b0;
            ctrl_reg    <= '0;
            illegal_reg <= 1'b0;
        end
    end

    assign out_valid = valid_reg;
    assign RegWrite  = ctrl_reg.reg_write;
    assign ImmSrc    = ctrl_reg.imm_src;
    assign ALUSrc    = ctrl_reg.alu_src;
    assign MemWrite  = ctrl_reg.mem_write;
    assign ResultSrc = ctrl_reg.result_src;
    assign Branch    = ctrl_reg.branch;
    assign Jump      = ctrl_reg.jump;
    assign ALUOp     = ctrl_reg.alu_op;
    assign illegal   = illegal_reg;
    assign ill_cnt   = ill_cnt_reg;

endmodule
